// File: rtl/demux_1x2_stream.sv
// Registered 1-to-2 stream demultiplexer with a 2-entry FIFO per output channel.
// Optional per-channel delivered-word counters are enabled by DEMUX_1X2_STREAM_COUNT_EN.
module demux_1x2_stream #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sel,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out0_valid,
   input  logic             out0_ready,
   output logic [WIDTH-1:0] out0_data,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic [WIDTH-1:0] out1_data
`ifdef DEMUX_1X2_STREAM_COUNT_EN
   ,
   output logic [15:0]      cnt0,
   output logic [15:0]      cnt1
`endif
);

   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StOne   = 2'd1,
      StTwo   = 2'd2
   } state_e;

   logic en0, en1;
   logic push0, push1;
   logic pop0, pop1;

   state_e state0_q, state0_d;
   state_e state1_q, state1_d;
   logic   wptr0_q, wptr0_d, rptr0_q, rptr0_d;
   logic   wptr1_q, wptr1_d, rptr1_q, rptr1_d;
   logic   full0_q, full1_q;

   logic [WIDTH-1:0] mem0_q [2];
   logic [WIDTH-1:0] mem1_q [2];

   assign en0 = ~sel;
   assign en1 = sel;

   // Ready looks only at sel and registered full flags, never at the consumers.
   assign in_ready = sel ? ~full1_q : ~full0_q;

   assign push0 = in_valid & in_ready & en0;
   assign push1 = in_valid & in_ready & en1;
   assign pop0  = out0_valid & out0_ready;
   assign pop1  = out1_valid & out1_ready;

   assign out0_valid = (state0_q != StEmpty);
   assign out1_valid = (state1_q != StEmpty);
   assign out0_data  = mem0_q[rptr0_q];
   assign out1_data  = mem1_q[rptr1_q];

   // Channel 0 next-state
   always_comb begin
      state0_d = state0_q;
      wptr0_d  = wptr0_q;
      rptr0_d  = rptr0_q;
      if (push0) wptr0_d = ~wptr0_q;
      if (pop0)  rptr0_d = ~rptr0_q;
      case (state0_q)
         StEmpty: begin
            if (push0) state0_d = StOne;
         end
         StOne: begin
            if (push0 && !pop0)      state0_d = StTwo;
            else if (pop0 && !push0) state0_d = StEmpty;
         end
         StTwo: begin
            if (pop0) state0_d = StOne;
         end
         default: state0_d = StEmpty;
      endcase
   end

   // Channel 1 next-state
   always_comb begin
      state1_d = state1_q;
      wptr1_d  = wptr1_q;
      rptr1_d  = rptr1_q;
      if (push1) wptr1_d = ~wptr1_q;
      if (pop1)  rptr1_d = ~rptr1_q;
      case (state1_q)
         StEmpty: begin
            if (push1) state1_d = StOne;
         end
         StOne: begin
            if (push1 && !pop1)      state1_d = StTwo;
            else if (pop1 && !push1) state1_d = StEmpty;
         end
         StTwo: begin
            if (pop1) state1_d = StOne;
         end
         default: state1_d = StEmpty;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state0_q  <= StEmpty;
         wptr0_q   <= 1'b0;
         rptr0_q   <= 1'b0;
         full0_q   <= 1'b0;
         mem0_q[0] <= '0;
         mem0_q[1] <= '0;
      end else begin
         state0_q <= state0_d;
         wptr0_q  <= wptr0_d;
         rptr0_q  <= rptr0_d;
         full0_q  <= (state0_d == StTwo);
         if (push0) mem0_q[wptr0_q] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state1_q  <= StEmpty;
         wptr1_q   <= 1'b0;
         rptr1_q   <= 1'b0;
         full1_q   <= 1'b0;
         mem1_q[0] <= '0;
         mem1_q[1] <= '0;
      end else begin
         state1_q <= state1_d;
         wptr1_q  <= wptr1_d;
         rptr1_q  <= rptr1_d;
         full1_q  <= (state1_d == StTwo);
         if (push1) mem1_q[wptr1_q] <= in_data;
      end
   end

`ifdef DEMUX_1X2_STREAM_COUNT_EN
   logic [15:0] cnt0_q, cnt1_q;

   // Free-running wrap, no saturation.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt0_q <= 16'h0000;
         cnt1_q <= 16'h0000;
      end else begin
         if (pop0) cnt0_q <= cnt0_q + 16'h0001;
         if (pop1) cnt1_q <= cnt1_q + 16'h0001;
      end
   end

   assign cnt0 = cnt0_q;
   assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_demux_1x2_stream.sv
// Self-checking bench for demux_1x2_stream: directed vector table, reset corner cases,
// randomized traffic against a queue-based model, and counter wrap when counters are built.
module tb_demux_1x2_stream;

   localparam int unsigned WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             sel;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out0_valid, out0_ready;
   logic [WIDTH-1:0] out0_data;
   logic             out1_valid, out1_ready;
   logic [WIDTH-1:0] out1_data;
`ifdef DEMUX_1X2_STREAM_COUNT_EN
   logic [15:0]      cnt0, cnt1;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   demux_1x2_stream #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .sel        (sel),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out0_valid (out0_valid),
      .out0_ready (out0_ready),
      .out0_data  (out0_data),
      .out1_valid (out1_valid),
      .out1_ready (out1_ready),
      .out1_data  (out1_data)
`ifdef DEMUX_1X2_STREAM_COUNT_EN
      ,
      .cnt0       (cnt0),
      .cnt1       (cnt1)
`endif
   );

   typedef struct {
      logic       s;
      logic       v;
      logic [7:0] d;
      logic       r0;
      logic       r1;
      logic       e_ir;
      logic       e_v0;
      logic [7:0] e_d0;
      logic       e_v1;
      logic [7:0] e_d1;
   } vec_t;

   vec_t tbl [16];

   // Reference model: one queue per channel plus delivered counts.
   logic [7:0]  q0 [$];
   logic [7:0]  q1 [$];
   logic [15:0] m_cnt0 = 16'h0;
   logic [15:0] m_cnt1 = 16'h0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Apply inputs after the falling edge; outputs are checked 1 time unit later.
   task automatic drive(input logic r, input logic s, input logic v, input logic [7:0] d,
                        input logic r0, input logic r1);
      @(negedge clk);
      rst        = r;
      sel        = s;
      in_valid   = v;
      in_data    = d;
      out0_ready = r0;
      out1_ready = r1;
      #1;
   endtask

   task automatic model_step(input logic r, input logic s, input logic v, input logic [7:0] d,
                             input logic r0, input logic r1);
      logic e_ir;
      logic pop0, pop1, push0, push1;
      drive(r, s, v, d, r0, r1);
      e_ir = s ? (q1.size() < 2) : (q0.size() < 2);
      check("rnd_in_ready", in_ready, e_ir);
      check("rnd_out0_valid", out0_valid, q0.size() != 0);
      check("rnd_out1_valid", out1_valid, q1.size() != 0);
      if (q0.size() != 0) check("rnd_out0_data", out0_data, q0[0]);
      if (q1.size() != 0) check("rnd_out1_data", out1_data, q1[0]);
`ifdef DEMUX_1X2_STREAM_COUNT_EN
      check("rnd_cnt0", cnt0, m_cnt0);
      check("rnd_cnt1", cnt1, m_cnt1);
`endif
      if (r) begin
         q0.delete();
         q1.delete();
         m_cnt0 = 16'h0;
         m_cnt1 = 16'h0;
      end else begin
         pop0  = (q0.size() != 0) && r0;
         pop1  = (q1.size() != 0) && r1;
         push0 = v && e_ir && !s;
         push1 = v && e_ir && s;
         if (pop0) begin
            void'(q0.pop_front());
            m_cnt0 = m_cnt0 + 16'h1;
         end
         if (pop1) begin
            void'(q1.pop_front());
            m_cnt1 = m_cnt1 + 16'h1;
         end
         if (push0) q0.push_back(d);
         if (push1) q1.push_back(d);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0, p1;
      rst = 1'b1; sel = 1'b0; in_valid = 1'b0; in_data = '0;
      out0_ready = 1'b0; out1_ready = 1'b0;

      //            s    v    d      r0   r1   ir   v0   d0     v1   d1
      tbl[0]  = '{1'b0,1'b1,8'h11,1'b1,1'b1,1'b1,1'b0,8'h00,1'b0,8'h00};
      tbl[1]  = '{1'b1,1'b1,8'h22,1'b1,1'b1,1'b1,1'b1,8'h11,1'b0,8'h00};
      tbl[2]  = '{1'b0,1'b0,8'h00,1'b1,1'b1,1'b1,1'b0,8'h00,1'b1,8'h22};
      tbl[3]  = '{1'b0,1'b0,8'h00,1'b1,1'b1,1'b1,1'b0,8'h00,1'b0,8'h00};
      tbl[4]  = '{1'b0,1'b1,8'hA0,1'b0,1'b1,1'b1,1'b0,8'h00,1'b0,8'h00};
      tbl[5]  = '{1'b0,1'b1,8'hA1,1'b0,1'b1,1'b1,1'b1,8'hA0,1'b0,8'h00};
      tbl[6]  = '{1'b0,1'b1,8'hFF,1'b0,1'b1,1'b0,1'b1,8'hA0,1'b0,8'h00};
      tbl[7]  = '{1'b1,1'b0,8'h00,1'b0,1'b1,1'b1,1'b1,8'hA0,1'b0,8'h00};
      tbl[8]  = '{1'b0,1'b0,8'h00,1'b1,1'b1,1'b0,1'b1,8'hA0,1'b0,8'h00};
      tbl[9]  = '{1'b0,1'b0,8'h00,1'b1,1'b1,1'b1,1'b1,8'hA1,1'b0,8'h00};
      tbl[10] = '{1'b0,1'b0,8'h00,1'b1,1'b1,1'b1,1'b0,8'h00,1'b0,8'h00};
      tbl[11] = '{1'b0,1'b1,8'h05,1'b0,1'b1,1'b1,1'b0,8'h00,1'b0,8'h00};
      tbl[12] = '{1'b0,1'b1,8'h06,1'b1,1'b1,1'b1,1'b1,8'h05,1'b0,8'h00};
      tbl[13] = '{1'b0,1'b0,8'h00,1'b0,1'b1,1'b1,1'b1,8'h06,1'b0,8'h00};
      tbl[14] = '{1'b0,1'b0,8'h00,1'b1,1'b1,1'b1,1'b1,8'h06,1'b0,8'h00};
      tbl[15] = '{1'b0,1'b0,8'h00,1'b1,1'b1,1'b1,1'b0,8'h00,1'b0,8'h00};

      // Reset for two cycles, then idle.
      drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      check("rst_out0_valid", out0_valid, 1'b0);
      check("rst_out1_valid", out1_valid, 1'b0);
      check("rst_in_ready_s0", in_ready, 1'b1);
      check("rst_out0_data", out0_data, 8'h00);
      check("rst_out1_data", out1_data, 8'h00);
`ifdef DEMUX_1X2_STREAM_COUNT_EN
      check("rst_cnt0", cnt0, 16'h0);
      check("rst_cnt1", cnt1, 16'h0);
`endif

      for (int i = 0; i < 16; i++) begin
         drive(1'b0, tbl[i].s, tbl[i].v, tbl[i].d, tbl[i].r0, tbl[i].r1);
         check($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].e_ir);
         check($sformatf("vec%0d_out0_valid", i), out0_valid, tbl[i].e_v0);
         check($sformatf("vec%0d_out1_valid", i), out1_valid, tbl[i].e_v1);
         if (tbl[i].e_v0) check($sformatf("vec%0d_out0_data", i), out0_data, tbl[i].e_d0);
         if (tbl[i].e_v1) check($sformatf("vec%0d_out1_data", i), out1_data, tbl[i].e_d1);
      end
`ifdef DEMUX_1X2_STREAM_COUNT_EN
      check("tbl_cnt0", cnt0, 16'd5);
      check("tbl_cnt1", cnt1, 16'd1);
`endif

      // Fill both channels, then reset mid-operation.
      drive(1'b0, 1'b0, 1'b1, 8'hC0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 8'hC1, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 8'hD0, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 8'hD1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 8'hEE, 1'b0, 1'b0);
      check("full0_in_ready", in_ready, 1'b0);
      check("full0_out0_data", out0_data, 8'hC0);
      drive(1'b0, 1'b1, 1'b1, 8'hEE, 1'b0, 1'b0);
      check("full1_in_ready", in_ready, 1'b0);
      check("full1_out1_data", out1_data, 8'hD0);
      drive(1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      check("midrst_out0_valid", out0_valid, 1'b0);
      check("midrst_out1_valid", out1_valid, 1'b0);
      check("midrst_in_ready_s0", in_ready, 1'b1);
      check("midrst_out0_data", out0_data, 8'h00);
      check("midrst_out1_data", out1_data, 8'h00);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
         check("midrst_in_ready_s1", in_ready, 1'b1);
         check("midrst_stale0", out0_valid, 1'b0);
         check("midrst_stale1", out1_valid, 1'b0);
      end

      // Randomized traffic against the queue model.
      model_step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      p0 = 0;
      p1 = 0;
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) begin
            p0 = int'($urandom_range(0, 3));
            p1 = int'($urandom_range(0, 3));
         end
         model_step(($urandom_range(0, 255) == 0), 1'($urandom), 1'($urandom),
                    8'($urandom), (int'($urandom_range(0, 3)) >= p0),
                    (int'($urandom_range(0, 3)) >= p1));
      end

`ifdef DEMUX_1X2_STREAM_COUNT_EN
      // 65536 pops on channel 1 wrap its counter back to zero.
      model_step(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
      for (int i = 0; i < 65536; i++) model_step(1'b0, 1'b1, 1'b1, 8'(i), 1'b1, 1'b1);
      model_step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
      check("pre_wrap_cnt1", cnt1, 16'hFFFF);
      model_step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
      check("wrap_cnt1", cnt1, 16'h0000);
      check("wrap_cnt0", cnt0, 16'h0000);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/demux_1x2_stream.md
# demux_1x2_stream

Registered 1-to-2 stream demultiplexer that sits directly downstream of the 1x2 decoder stage. It uses the `sel` bit to route each accepted input word into one of two output channels. Each channel owns a 2-entry FIFO, so a stall on one channel never corrupts or reorders the other. Full throughput is sustained with no combinational path from either `outN_ready` to `in_ready`.

## Interface
Parameters:
- WIDTH, 8, data word width in bits (≥1)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- sel  input  1  channel select, sampled with `in_data`: 0 → channel 0, 1 → channel 1
- in_valid  input  1  upstream word present
- in_ready  output  1  selected channel can accept a word this cycle
- in_data  input  WIDTH  upstream word
- out0_valid  output  1  channel 0 head entry valid
- out0_ready  input  1  channel 0 consumer accepts head
- out0_data  output  WIDTH  channel 0 head entry
- out1_valid  output  1  channel 1 head entry valid
- out1_ready  input  1  channel 1 consumer accepts head
- out1_data  output  WIDTH  channel 1 head entry
- cnt0  output  16  channel 0 delivered-word count (only with DEMUX_1X2_STREAM_COUNT_EN)
- cnt1  output  16  channel 1 delivered-word count (only with DEMUX_1X2_STREAM_COUNT_EN)

## Operation
- The decode of `sel` gives enables `en0 = ~sel` and `en1 = sel`. Exactly one channel is addressed each cycle.
- Per-channel state machine: EMPTY (0 entries), ONE (1 entry), TWO (2 entries, full).
- Per-channel storage: 2 entries, 1-bit write pointer, 1-bit read pointer. Both pointers wrap 1 → 0.
- Push to channel N: `in_valid & in_ready & enN`.
- Pop from channel N: `outN_valid & outN_ready`.
- `in_ready = sel ? ~full1 : ~full0`, where `fullN` is a registered flag equal to (state == TWO). `in_ready` depends only on `sel` and registered flags.
- `outN_valid = (stateN != EMPTY)`. `outN_data` is the entry at the read pointer. Data is held stable while `outN_valid & ~outN_ready`.
- State transitions per channel:
  - EMPTY: push → ONE.
  - ONE: push without pop → TWO; pop without push → EMPTY; push and pop together → ONE.
  - TWO: pop → ONE. A push cannot occur because `in_ready` is low.
- A push with pop in the same cycle, when the channel is in ONE, writes the new word to the write slot and advances the read pointer. Order is preserved.
- Words within a channel leave in acceptance order. No ordering between channels is defined.
- When `in_valid` is low, or `in_ready` is low, no state changes except pops.
- `sel` toggling while the input is stalled is legal. `in_ready` re-evaluates for the new channel in the same cycle.

## Timing
- Reset (rst high at a clk edge), regardless of in-flight traffic:
  - both states go to EMPTY and all pointers to 0;
  - `out0_valid = out1_valid = 0`;
  - storage entries and `outN_data` go to 0;
  - `cnt0 = cnt1 = 0`;
  - `in_ready = 1` from the first cycle after reset.
- While rst is high, pushes and pops are ignored.
- Latency: a word accepted at edge k appears on `outN_data` with `outN_valid = 1` in the cycle after edge k, if the channel was EMPTY.
- Throughput: 1 word/cycle sustained into either channel while its consumer holds ready high.
- A channel in TWO with a pop at edge k raises `in_ready` for that channel after edge k. There is one cycle of bubble relative to the pop, which is intentional and keeps `in_ready` registered.
- Counters update at the same edge as the pop. They wrap 0xFFFF → 0x0000 with no saturation.

## Configuration
- DEMUX_1X2_STREAM_COUNT_EN defined:
  - ports `cnt0` and `cnt1` exist;
  - each is a 16-bit register that increments by 1 on every pop of its channel.
- DEMUX_1X2_STREAM_COUNT_EN undefined:
  - ports `cnt0`, `cnt1` and their registers are absent;
  - all other behaviour is identical.

## Test plan
- Reset then idle: rst=1 for 2 cycles, then 0 → `out0_valid = out1_valid = 0`, `in_ready = 1`, `cnt0 = cnt1 = 0`.
- Route: push 0x11 (sel=0), then 0x22 (sel=1), both consumers ready=1 → `out0_data = 0x11` and `out1_data = 0x22`, each valid exactly 1 cycle, one cycle after acceptance; `cnt0 = 1`, `cnt1 = 1`.
- Fill and back-pressure: `out0_ready = 0`, push 0xA0, 0xA1 on sel=0 → channel 0 in TWO, `in_ready = 0` while sel=0, `in_ready = 1` with sel=1. Raise `out0_ready` → 0xA0 then 0xA1 delivered in order.
- Simultaneous push/pop: channel 0 in ONE holding 0x05, push 0x06 while popping → channel 0 stays ONE and `out0_data = 0x06` next cycle.
- Reset mid-operation: both channels in TWO, assert rst for 1 cycle → all valids 0, `in_ready = 1`, and no stale data is delivered afterwards.
- Counter wrap (COUNT_EN defined): 65536 pops on channel 1 → `cnt1` returns to 0x0000 and `cnt0` is unchanged.
